// File: rtl/time_surface_encoder_if.sv
// Event, clear and read-port bundle for time_surface_encoder.
// master drives events and reads; slave is the encoder.
interface time_surface_encoder_if #(
  parameter int COORD_BITS = 7,
  parameter int ADDR_BITS  = 8,
  parameter int VALUE_BITS = 8
);
  logic                  event_valid;
  logic                  event_ready;
  logic [COORD_BITS-1:0] event_x;
  logic [COORD_BITS-1:0] event_y;
  logic                  event_polarity;
  logic                  clear_req;
  logic [ADDR_BITS-1:0]  ts_read_addr;
  logic                  ts_read_enable;
  logic [VALUE_BITS-1:0] ts_read_value;
  logic                  busy;
  logic [15:0]           debug_event_count;

  modport master (
    output event_valid, event_x, event_y, event_polarity, clear_req,
           ts_read_addr, ts_read_enable,
    input  event_ready, ts_read_value, busy, debug_event_count
  );

  modport slave (
    input  event_valid, event_x, event_y, event_polarity, clear_req,
           ts_read_addr, ts_read_enable,
    output event_ready, ts_read_value, busy, debug_event_count
  );
endinterface

// File: rtl/time_surface_encoder.sv
// Per-cell DVS time surface with linear decay readout and a stale-cell scrubber.
// Optional macro TS_ON_ONLY_EN: OFF-polarity events are handshaken but discarded.
module time_surface_encoder #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int TICK_CYCLES = CLK_FREQ_HZ / 1000,
  parameter int SENSOR_RES  = 128,
  parameter int COORD_BITS  = $clog2(SENSOR_RES),
  parameter int GRID_SIZE   = 16,
  parameter int ADDR_BITS   = $clog2(GRID_SIZE * GRID_SIZE),
  parameter int VALUE_BITS  = 8,
  parameter int TS_BITS     = 16,
  parameter int DECAY_STEP  = 4
) (
  input logic                   clk,
  input logic                   rst,
  time_surface_encoder_if.slave bus
);
  // state | meaning
  // CLEAR | port B wipes one cell per cycle, events refused, busy=1
  // RUN   | events accepted, scrubber uses idle port B cycles
  localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int CELL_BITS = $clog2(GRID_SIZE);
  localparam int SHIFT     = COORD_BITS - CELL_BITS;
  localparam int DEC_W     = TS_BITS + 8;
  localparam int TICK_W    = $clog2(TICK_CYCLES + 1);
  localparam logic [DEC_W-1:0]     VMAX      = DEC_W'((1 << VALUE_BITS) - 1);
  localparam logic [DEC_W-1:0]     DSTEP     = DEC_W'(DECAY_STEP);
  localparam logic [ADDR_BITS-1:0] LAST_CELL = ADDR_BITS'(NUM_CELLS - 1);
  localparam logic [TICK_W-1:0]    TICK_LOAD = TICK_W'(TICK_CYCLES - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                state, state_nxt;
  logic [TICK_W-1:0]     tick_cnt;
  logic [TS_BITS-1:0]    now;
  logic [TS_BITS:0]      mem [NUM_CELLS];
  logic [ADDR_BITS-1:0]  clear_idx, ev_addr, ev_addr_q, scrub_idx, b_addr;
  logic [CELL_BITS-1:0]  x_cell, y_cell;
  logic                  ev_keep, ev_fire, ev_pend;
  logic                  scrub_phase, scrub_hit, scrub_stale;
  logic                  b_we, b_re;
  logic [TS_BITS:0]      b_wdata, rd_q, scrub_q;
  logic [DEC_W-1:0]      rd_dec, scrub_dec;
  logic                  rd_en_q;
  logic [VALUE_BITS-1:0] value_q, value_nxt;
  logic [15:0]           ev_count;

  function automatic logic [DEC_W-1:0] age_dec(input logic [TS_BITS-1:0] now_v,
                                                input logic [TS_BITS-1:0] ts_v);
    logic [TS_BITS-1:0] age;
    age = now_v - ts_v;
    return DEC_W'(age) * DSTEP;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= TICK_LOAD;
      now      <= '0;
    end else if (tick_cnt == '0) begin
      tick_cnt <= TICK_LOAD;
      now      <= now + TS_BITS'(1);
    end else begin
      tick_cnt <= tick_cnt - TICK_W'(1);
    end
  end

`ifdef TS_ON_ONLY_EN
  assign ev_keep = bus.event_polarity;
`else
  // both polarities are stored alike
  assign ev_keep = bus.event_polarity | 1'b1;
`endif

  assign x_cell  = CELL_BITS'(bus.event_x >> SHIFT);
  assign y_cell  = CELL_BITS'(bus.event_y >> SHIFT);
  assign ev_addr = ADDR_BITS'({y_cell, x_cell});
  assign ev_fire = bus.event_valid && bus.event_ready && ev_keep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_pend   <= 1'b0;
      ev_addr_q <= '0;
      ev_count  <= '0;
    end else begin
      ev_pend   <= ev_fire;
      ev_addr_q <= ev_addr;
      if (ev_fire && ev_count != 16'hFFFF) ev_count <= ev_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clear_idx <= '0;
    end else begin
      state <= state_nxt;
      if (bus.clear_req)         clear_idx <= '0;
      else if (state == ST_CLEAR) clear_idx <= clear_idx + ADDR_BITS'(1);
    end
  end

  assign scrub_dec   = age_dec(now, scrub_q[TS_BITS-1:0]);
  assign scrub_stale = scrub_q[TS_BITS] && (scrub_dec >= VMAX);

  // Port B priority: clear, then event write, then scrubber read/write.
  always_comb begin
    state_nxt = state;
    b_we      = 1'b0;
    b_re      = 1'b0;
    b_addr    = scrub_idx;
    b_wdata   = '0;
    case (state)
      ST_CLEAR: begin
        b_we   = 1'b1;
        b_addr = clear_idx;
        if (!bus.clear_req && clear_idx == LAST_CELL) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.clear_req) state_nxt = ST_CLEAR;
        if (ev_pend) begin
          b_we    = 1'b1;
          b_addr  = ev_addr_q;
          b_wdata = {1'b1, now};
        end else if (!scrub_phase) begin
          b_re = 1'b1;
        end else begin
          b_we = scrub_stale && !scrub_hit;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // scrub_hit drops a pending invalidation if an event refreshed the cell meanwhile
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scrub_phase <= 1'b0;
      scrub_hit   <= 1'b0;
      scrub_idx   <= '0;
    end else if (state != ST_RUN) begin
      scrub_phase <= 1'b0;
      scrub_hit   <= 1'b0;
    end else if (ev_pend) begin
      if (scrub_phase && ev_addr_q == scrub_idx) scrub_hit <= 1'b1;
    end else if (!scrub_phase) begin
      scrub_phase <= 1'b1;
      scrub_hit   <= 1'b0;
    end else begin
      scrub_phase <= 1'b0;
      scrub_idx   <= scrub_idx + ADDR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
    if (b_re) scrub_q <= mem[b_addr];
    rd_q <= mem[bus.ts_read_addr];
  end

  assign rd_dec    = age_dec(now, rd_q[TS_BITS-1:0]);
  assign value_nxt = (rd_q[TS_BITS] && rd_dec < VMAX) ? VALUE_BITS'(VMAX - rd_dec) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q <= 1'b0;
      value_q <= '0;
    end else begin
      rd_en_q <= bus.ts_read_enable;
      value_q <= rd_en_q ? value_nxt : '0;
    end
  end

  assign bus.event_ready       = (state == ST_RUN);
  assign bus.busy              = (state == ST_CLEAR);
  assign bus.ts_read_value     = value_q;
  assign bus.debug_event_count = ev_count;
endmodule

// File: tb/tb_time_surface_encoder.sv
// Scoreboard bench for time_surface_encoder; one tick per clock so the
// timestamp wrap is reachable. Expected read values are hand-computed ages.
module tb_time_surface_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_surface_encoder_if #(.COORD_BITS(7), .ADDR_BITS(8), .VALUE_BITS(8)) tse ();

  time_surface_encoder #(.TICK_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tse)
  );

  typedef struct {
    int addr;
    int exp;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   cyc       = 0;
  int   exp_count = 0;
  logic en_d1 = 1'b0, en_d2 = 1'b0, en_d3 = 1'b0;

  // cyc equals the DUT's tick value with TICK_CYCLES = 1
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  always @(posedge clk) begin
    en_d1 <= tse.ts_read_enable;
    en_d2 <= en_d1;
    en_d3 <= en_d2;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (!rst) begin
      if (en_d2) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL read_unexpected: value %0d with empty scoreboard", tse.ts_read_value);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("read addr %0d", e.addr), int'(tse.ts_read_value), e.exp);
        end
      end else if (en_d3) begin
        check("read_idle_zero", int'(tse.ts_read_value), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input int addr, input int exp);
    tse.ts_read_enable = 1'b1;
    tse.ts_read_addr   = 8'(addr);
    step();
    exp_q.push_back('{addr, exp});
    tse.ts_read_enable = 1'b0;
  endtask

  task automatic send_event(input int x, input int y, input bit pol);
    logic rdy;
    tse.event_valid    = 1'b1;
    tse.event_x        = 7'(x);
    tse.event_y        = 7'(y);
    tse.event_polarity = pol;
    rdy = tse.event_ready;
    step();
`ifdef TS_ON_ONLY_EN
    if (rdy && pol) exp_count++;
`else
    if (rdy) exp_count++;
`endif
    tse.event_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  initial begin
    #(10 * 100_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int busy_cnt;
    bit refused;
    tse.event_valid    = 1'b0;
    tse.event_x        = '0;
    tse.event_y        = '0;
    tse.event_polarity = 1'b0;
    tse.clear_req      = 1'b0;
    tse.ts_read_addr   = '0;
    tse.ts_read_enable = 1'b0;

    repeat (3) @(negedge clk);
    check("reset event_ready", int'(tse.event_ready), 0);
    check("reset busy", int'(tse.busy), 1);
    check("reset ts_read_value", int'(tse.ts_read_value), 0);
    check("reset debug_event_count", int'(tse.debug_event_count), 0);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tse.event_ready) break;
    end
    check("ready_rise_edge", cyc, 256);
    check("busy_low_at_ready", int'(tse.busy), 0);
    step();

    for (int a = 0; a < 256; a++) issue_read(a, 0);

    // (127,0) -> cell 15; read in N+1 is read-first, N+2 sees age 2
    send_event(127, 0, 1'b1);
    a0 = cyc;
    issue_read(15, 0);
    issue_read(15, 247);
    wait_until(a0 + 9);
    issue_read(15, 215);
    wait_until(a0 + 62);
    issue_read(15, 3);
    issue_read(15, 0);

    // back-to-back events to cells 1, 18, 255, 72, read newest first
    send_event(8, 0, 1'b1);
    a0 = cyc;
    send_event(16, 8, 1'b1);
    send_event(120, 120, 1'b1);
    send_event(64, 32, 1'b1);
    step();
    issue_read(72, 247);
    issue_read(255, 239);
    issue_read(18, 231);
    issue_read(1, 223);
    step();
    check("event_count_5", int'(tse.debug_event_count), exp_count);

    // wrap: without scrubbing the aliased age would be 5 -> 235
    send_event(0, 127, 1'b1);
    a0 = cyc;
    wait_until(a0 + 65536 + 4);
    issue_read(240, 0);
    issue_read(72, 0);

    send_event(40, 40, 1'b1);
    step();
    tse.clear_req = 1'b1;
    step();
    tse.clear_req      = 1'b0;
    tse.event_valid    = 1'b1;
    tse.event_x        = '0;
    tse.event_y        = '0;
    tse.event_polarity = 1'b1;
    busy_cnt = 0;
    refused  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!tse.busy) break;
      busy_cnt++;
      if (tse.event_ready) refused = 1'b0;
    end
    tse.event_valid = 1'b0;
    check("clear_busy_cycles", busy_cnt, 256);
    check("clear_events_refused", int'(refused), 1);
    check("clear_count_unchanged", int'(tse.debug_event_count), exp_count);
    step();
    for (int a = 0; a < 256; a++) issue_read(a, 0);

    send_event(40, 40, 1'b1);
    step();
    issue_read(85, 247);

    send_event(0, 0, 1'b0);
    step();
`ifdef TS_ON_ONLY_EN
    issue_read(0, 0);
`else
    issue_read(0, 247);
`endif
    step();
    check("polarity_event_count", int'(tse.debug_event_count), exp_count);

    repeat (4) step();
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d reads never answered, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
